// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: FSM encoding and
// default timing constants for a 50 MHz system clock.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        LONG_HELD    = 3'd3,
        RELEASE_WAIT = 3'd4
    } btn_state_t;

    // 10 ms debounce window and 1 s long-press threshold at 50 MHz
    localparam int unsigned DEB_10MS = 500000;
    localparam int unsigned HOLD_1S  = 50000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pad input; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button pin, producing a clean level
// plus one-cycle press, release and long-press pulses, all registered.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS,
    parameter int unsigned HOLD_CYCLES     = HOLD_1S
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    // A one-sample window accepts a level change on the first differing sample
    localparam bit FAST = (DEBOUNCE_CYCLES == 1);

    btn_state_t    state, state_nxt;
    logic [DW-1:0] deb_cnt, deb_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          was_long, was_long_nxt;
    logic          s;
    logic          level_nxt, press_nxt, release_nxt, long_nxt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            was_long      <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            state         <= state_nxt;
            deb_cnt       <= deb_nxt;
            hold_cnt      <= hold_nxt;
            was_long      <= was_long_nxt;
            level         <= level_nxt;
            press         <= press_nxt;
            release_pulse <= release_nxt;
            long_press    <= long_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        deb_nxt      = deb_cnt;
        hold_nxt     = hold_cnt;
        was_long_nxt = was_long;
        unique case (state)
            IDLE: begin
                deb_nxt = '0;
                if (s) begin
                    if (FAST) begin
                        state_nxt = HELD;
                        hold_nxt  = '0;
                    end else begin
                        state_nxt = PRESS_WAIT;
                        deb_nxt   = DEB_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_MAX) begin
                    state_nxt = HELD;
                    deb_nxt   = '0;
                    hold_nxt  = '0;
                end else begin
                    deb_nxt = deb_cnt + DEB_ONE;
                end
            end
            HELD: begin
                // Reaching the hold threshold wins; a low sample is then handled from LONG_HELD
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = LONG_HELD;
                    hold_nxt  = HOLD_MAX;
                end else begin
                    hold_nxt = hold_cnt + HOLD_ONE;
                    if (!s) begin
                        was_long_nxt = 1'b0;
                        if (FAST) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = RELEASE_WAIT;
                            deb_nxt   = DEB_ONE;
                        end
                    end
                end
            end
            LONG_HELD: begin
                if (!s) begin
                    was_long_nxt = 1'b1;
                    if (FAST) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RELEASE_WAIT;
                        deb_nxt   = DEB_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = was_long ? LONG_HELD : HELD;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_MAX) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + DEB_ONE;
                end
            end
            default: begin
                state_nxt    = IDLE;
                deb_nxt      = '0;
                hold_nxt     = '0;
                was_long_nxt = 1'b0;
            end
        endcase
    end

    // Pulses are decoded from the transition being taken, then registered
    always_comb begin
        level_nxt   = (state_nxt == HELD) || (state_nxt == LONG_HELD) ||
                      (state_nxt == RELEASE_WAIT);
        press_nxt   = ((state == IDLE) || (state == PRESS_WAIT)) && (state_nxt == HELD);
        release_nxt = ((state == HELD) || (state == LONG_HELD) ||
                       (state == RELEASE_WAIT)) && (state_nxt == IDLE);
        long_nxt    = (state == HELD) && (state_nxt == LONG_HELD);
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: a DEBOUNCE=4/HOLD=10 instance for the main scenarios and a
// DEBOUNCE=1 instance for the minimum-window case.
module tb_button_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic btn_a, btn_b;
    logic level_a, press_a, rel_a, long_a;
    logic level_b, press_b, rel_b, long_b;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    button_conditioner #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10)) dut_a (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_a),
        .level         (level_a),
        .press         (press_a),
        .release_pulse (rel_a),
        .long_press    (long_a)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(1), .HOLD_CYCLES(10)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .btn_raw       (btn_b),
        .level         (level_b),
        .press         (press_b),
        .release_pulse (rel_b),
        .long_press    (long_b)
    );

    // Advance one active edge and settle; outputs then show that edge's result
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn_a = 1'b1;
        btn_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({level_a, press_a, rel_a, long_a, level_b, press_b, rel_b, long_b} !== 8'h00)
                $display("[TB] FAIL reset_outputs cycle %0d: got %b expected 00000000", i,
                         {level_a, press_a, rel_a, long_a, level_b, press_b, rel_b, long_b});
            else
                passed++;
        end
        btn_a = 1'b0;
        btn_b = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if ({level_a, press_a, rel_a, long_a} !== 4'b0000)
            $display("[TB] FAIL idle_after_reset: got %b expected 0000",
                     {level_a, press_a, rel_a, long_a});
        else
            passed++;
    endtask

    task automatic test_clean_press();
        logic [3:0] exp;
        btn_a = 1'b1;
        for (int e = 0; e <= 17; e++) begin
            tick();
            if (e < 6)       exp = 4'b0000;
            else if (e == 6) exp = 4'b1100;
            else if (e == 16) exp = 4'b1001;
            else             exp = 4'b1000;
            total++;
            if ({level_a, press_a, rel_a, long_a} !== exp)
                $display("[TB] FAIL clean_press edge %0d: got %b expected %b", e,
                         {level_a, press_a, rel_a, long_a}, exp);
            else
                passed++;
        end
    endtask

    task automatic test_full_release();
        logic [3:0] exp;
        btn_a = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (e < 6)       exp = 4'b1000;
            else if (e == 6) exp = 4'b0010;
            else             exp = 4'b0000;
            total++;
            if ({level_a, press_a, rel_a, long_a} !== exp)
                $display("[TB] FAIL full_release edge %0d: got %b expected %b", e,
                         {level_a, press_a, rel_a, long_a}, exp);
            else
                passed++;
        end
    endtask

    task automatic test_bounce();
        logic pattern [4];
        pattern = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int e = 0; e < 16; e++) begin
            btn_a = (e < 4) ? pattern[e] : 1'b0;
            tick();
            total++;
            if ({level_a, press_a, rel_a} !== 3'b000)
                $display("[TB] FAIL bounce edge %0d: got %b expected 000", e,
                         {level_a, press_a, rel_a});
            else
                passed++;
        end
    endtask

    task automatic test_release_bounce();
        logic [3:0] exp;
        btn_a = 1'b1;
        for (int e = 0; e < 6; e++) tick();
        tick();
        total++;
        if ({level_a, press_a, rel_a, long_a} !== 4'b1100)
            $display("[TB] FAIL rb_press: got %b expected 1100",
                     {level_a, press_a, rel_a, long_a});
        else
            passed++;
        // Dropping the pad for edges 9 and 10 costs two cycles of hold time
        for (int e = 7; e <= 19; e++) begin
            btn_a = (e == 9 || e == 10) ? 1'b0 : 1'b1;
            tick();
            exp = (e == 18) ? 4'b1001 : 4'b1000;
            total++;
            if ({level_a, press_a, rel_a, long_a} !== exp)
                $display("[TB] FAIL release_bounce edge %0d: got %b expected %b", e,
                         {level_a, press_a, rel_a, long_a}, exp);
            else
                passed++;
        end
    endtask

    task automatic test_reset_mid_press();
        logic [3:0] exp;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({level_a, press_a, rel_a, long_a} !== 4'b0000)
            $display("[TB] FAIL async_reset_clear: got %b expected 0000",
                     {level_a, press_a, rel_a, long_a});
        else
            passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({level_a, press_a, rel_a, long_a} !== 4'b0000)
                $display("[TB] FAIL reset_hold cycle %0d: got %b expected 0000", i,
                         {level_a, press_a, rel_a, long_a});
            else
                passed++;
        end
        reset = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e < 6)       exp = 4'b0000;
            else if (e == 6) exp = 4'b1100;
            else             exp = 4'b1000;
            total++;
            if ({level_a, press_a, rel_a, long_a} !== exp)
                $display("[TB] FAIL press_after_reset edge %0d: got %b expected %b", e,
                         {level_a, press_a, rel_a, long_a}, exp);
            else
                passed++;
        end
    endtask

    task automatic test_min_debounce();
        logic [3:0] exp;
        for (int e = 0; e <= 4; e++) begin
            btn_b = (e == 0) ? 1'b1 : 1'b0;
            tick();
            if (e == 2)      exp = 4'b1100;
            else if (e == 3) exp = 4'b0010;
            else             exp = 4'b0000;
            total++;
            if ({level_b, press_b, rel_b, long_b} !== exp)
                $display("[TB] FAIL min_debounce edge %0d: got %b expected %b", e,
                         {level_b, press_b, rel_b, long_b}, exp);
            else
                passed++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_full_release();
        test_bounce();
        test_release_bounce();
        test_reset_mid_press();
        test_min_debounce();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
